// File: rtl/spi_cmd_rx.sv
// SPI mode-0 slave front end for the DDS command path: synchronises the pins into
// sys_clk, collects {cmd, data} frames, strobes them out and shifts the last good frame back on MISO.
module spi_cmd_rx #(
  parameter int CMD_WIDTH      = 8,
  parameter int DATAWORD_WIDTH = 16,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      sys_clk,
  input  logic                      rst_n,
  input  logic                      spi_sclk,
  input  logic                      spi_cs_n,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic [CMD_WIDTH-1:0]      cmd_word,
  output logic [DATAWORD_WIDTH-1:0] data_word,
  output logic                      cmd_valid,
  output logic                      frame_err,
  output logic                      busy
);

  localparam int FRAME_LEN = CMD_WIDTH + DATAWORD_WIDTH;
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_LEN + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_hist;
  logic                   cs_hist;

  logic sclk_rise_q;
  logic sclk_fall_q;
  logic cs_fall_q;
  logic cs_rise_q;
  logic mosi_q;

  logic [0:0]           state;
  logic [FRAME_LEN-1:0] shift_reg;
  logic [FRAME_LEN-1:0] miso_shift;
  logic [FRAME_LEN-1:0] readback;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 commit_ok;
  logic                 commit_err;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // CS_N chain resets high so reset release never looks like a frame start
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_hist <= sclk_s;
      cs_hist   <= cs_s;
    end
  end

  // Registered edge pulses; MOSI travels with them so a rise sees its own data bit
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_rise_q <= ~sclk_hist & sclk_s;
      sclk_fall_q <= sclk_hist & ~sclk_s;
      cs_fall_q   <= cs_hist & ~cs_s;
      cs_rise_q   <= ~cs_hist & cs_s;
      mosi_q      <= mosi_s;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      miso_shift <= '0;
      readback   <= '0;
      bit_cnt    <= '0;
      commit_ok  <= 1'b0;
      commit_err <= 1'b0;
      cmd_word   <= '0;
      data_word  <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      commit_ok  <= 1'b0;
      commit_err <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;

      if (commit_ok) begin
        cmd_word  <= shift_reg[FRAME_LEN-1:DATAWORD_WIDTH];
        data_word <= shift_reg[DATAWORD_WIDTH-1:0];
        readback  <= shift_reg;
        cmd_valid <= 1'b1;
      end
      if (commit_err) begin
        frame_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cs_fall_q) begin
            state      <= SHIFT;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            // a frame committing this same cycle is the one to read back
            miso_shift <= commit_ok ? shift_reg : readback;
          end
        end
        SHIFT: begin
          if (cs_rise_q) begin
            state      <= IDLE;
            commit_ok  <= (bit_cnt == CNT_FULL);
            commit_err <= (bit_cnt != CNT_FULL);
          end else begin
            if (sclk_rise_q) begin
              shift_reg <= {shift_reg[FRAME_LEN-2:0], mosi_q};
              if (bit_cnt != CNT_SAT) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            if (sclk_fall_q) begin
              miso_shift <= {miso_shift[FRAME_LEN-2:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state == SHIFT);
  assign spi_miso = busy & miso_shift[FRAME_LEN-1];

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Bench for spi_cmd_rx: drives SPI mode-0 frames (directed and random) and checks
// decoded words, pulse timing and MISO readback against a frame-level model.
module tb_spi_cmd_rx;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [7:0]  cmd_word;
  logic [15:0] data_word;
  logic        cmd_valid;
  logic        frame_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // frame-level reference model
  logic [7:0]  exp_cmd = '0;
  logic [15:0] exp_data = '0;
  logic [23:0] exp_readback = '0;
  int          exp_valid_total = 0;
  int          exp_err_total = 0;

  int tot_valid = 0;
  int tot_err = 0;
  int both_high = 0;

  spi_cmd_rx #(.CMD_WIDTH(8), .DATAWORD_WIDTH(16), .SYNC_STAGES(SYNC)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .cmd_word(cmd_word), .data_word(data_word),
    .cmd_valid(cmd_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (cmd_valid) tot_valid++;
    if (frame_err) tot_err++;
    if (cmd_valid && frame_err) both_high++;
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic check_words(input string name);
    n_tests++;
    if (cmd_word !== exp_cmd || data_word !== exp_data) begin
      n_fail++;
      $display("FAIL %s words: got %h_%h expected %h_%h", name, cmd_word, data_word, exp_cmd, exp_data);
    end
  endtask

  task automatic run_frame(input logic [31:0] v, input int n, input bit coincident, input string name);
    logic [31:0] cap;
    logic [31:0] exp_miso;
    int vcnt;
    int ecnt;
    int vpos;
    bit good;
    cap = '0;
    exp_miso = '0;
    for (int i = 0; i < n && i < 24; i++) exp_miso[i] = exp_readback[23-i];
    good = (n == 24);

    wait_neg(1);
    spi_cs_n = 1'b0;
    wait_neg(SYNC + 4);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_in_frame: got %b expected 1", name, busy);
    end
    for (int i = 0; i < n; i++) begin
      spi_mosi = v[n-1-i];
      wait_neg(HALF);
      spi_sclk = 1'b1;
      cap[i] = spi_miso;
      wait_neg(HALF);
      spi_sclk = 1'b0;
    end
    wait_neg(HALF);
    if (coincident) spi_sclk = 1'b1;
    spi_cs_n = 1'b1;

    vcnt = 0; ecnt = 0; vpos = -1;
    for (int k = 0; k < 12; k++) begin
      @(posedge sys_clk);
      #1;
      if (cmd_valid === 1'b1) begin vcnt++; vpos = k; end
      if (frame_err === 1'b1) ecnt++;
    end
    wait_neg(1);
    spi_sclk = 1'b0;

    if (good) begin
      exp_cmd = v[23:16];
      exp_data = v[15:0];
      exp_readback = v[23:0];
      exp_valid_total++;
    end else begin
      exp_err_total++;
    end

    n_tests++;
    if (vcnt != (good ? 1 : 0) || ecnt != (good ? 0 : 1)) begin
      n_fail++;
      $display("FAIL %s pulses: got valid=%0d err=%0d expected valid=%0d err=%0d",
               name, vcnt, ecnt, good ? 1 : 0, good ? 0 : 1);
    end
    if (good) begin
      n_tests++;
      if (vpos != SYNC + 2) begin
        n_fail++;
        $display("FAIL %s latency: got %0d expected %0d", name, vpos, SYNC + 2);
      end
    end
    check_words(name);
    n_tests++;
    if (cap !== exp_miso) begin
      n_fail++;
      $display("FAIL %s miso: got %h expected %h", name, cap, exp_miso);
    end
    n_tests++;
    if (busy !== 1'b0 || spi_miso !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: got busy=%b miso=%b expected 0/0", name, busy, spi_miso);
    end
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_neg(1);
      spi_sclk = ~spi_sclk;
      spi_mosi = ~spi_mosi;
      if (cmd_word !== 8'h0 || data_word !== 16'h0 || cmd_valid !== 1'b0 || frame_err !== 1'b0 ||
          busy !== 1'b0 || spi_miso !== 1'b0) bad++;
    end
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(8);
    n_tests++;
    if (bad != 0 || tot_valid != 0 || tot_err != 0) begin
      n_fail++;
      $display("FAIL reset: got bad_cycles=%0d valid=%0d err=%0d expected 0/0/0", bad, tot_valid, tot_err);
    end
    check_words("reset");
  endtask

  task automatic test_good_frame();
    run_frame(32'h221234, 24, 1'b0, "good_frame");
  endtask

  task automatic test_bad_lengths();
    run_frame(32'h7ABCDE, 23, 1'b0, "short_23");
    run_frame(32'h1F0F0F0, 25, 1'b0, "long_25");
  endtask

  task automatic test_back_to_back();
    run_frame(32'h221234, 24, 1'b0, "b2b_first");
    run_frame(32'h810005, 24, 1'b0, "b2b_second");
  endtask

  task automatic test_reset_midframe();
    int bad;
    int v0;
    int e0;
    bad = 0;
    wait_neg(1);
    spi_cs_n = 1'b0;
    wait_neg(SYNC + 4);
    for (int i = 0; i < 10; i++) begin
      spi_mosi = 1'b1;
      wait_neg(HALF);
      spi_sclk = 1'b1;
      wait_neg(HALF);
      spi_sclk = 1'b0;
    end
    v0 = tot_valid;
    e0 = tot_err;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_neg(1);
      if (cmd_word !== 8'h0 || data_word !== 16'h0 || busy !== 1'b0 || spi_miso !== 1'b0) bad++;
    end
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(12);
    exp_cmd = '0;
    exp_data = '0;
    exp_readback = '0;
    n_tests++;
    if (bad != 0 || tot_valid != v0 || tot_err != e0) begin
      n_fail++;
      $display("FAIL reset_midframe: got bad_cycles=%0d new_valid=%0d new_err=%0d expected 0/0/0",
               bad, tot_valid - v0, tot_err - e0);
    end
    check_words("reset_midframe");
    run_frame(32'h1100AB, 24, 1'b0, "after_reset");
  endtask

  task automatic test_coincident();
    run_frame(32'h5AA5C3, 24, 1'b1, "coincident");
  endtask

  task automatic test_random();
    int n;
    logic [31:0] v;
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 3))
        0, 1:    n = 24;
        2:       n = $urandom_range(1, 30);
        default: n = ($urandom_range(0, 1) != 0) ? 23 : 25;
      endcase
      v = $urandom;
      run_frame(v, n, ($urandom_range(0, 3) == 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_lengths();
    test_back_to_back();
    test_reset_midframe();
    test_coincident();
    test_random();
    wait_neg(4);
    n_tests++;
    if (both_high != 0 || tot_valid != exp_valid_total || tot_err != exp_err_total) begin
      n_fail++;
      $display("FAIL totals: got valid=%0d err=%0d both=%0d expected valid=%0d err=%0d both=0",
               tot_valid, tot_err, both_high, exp_valid_total, exp_err_total);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete within bound");
    $fatal(1, "timeout");
  end

endmodule
